// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width/sign codes,
// FSM state encoding and the byte-count / legality lookups used when a
// request is accepted.
package lsu_pkg;

    // RV32I funct3 width/sign codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Number of bytes moved for a width code (1, 2 or 4)
    function automatic logic [2:0] lsu_nbytes(input logic [2:0] funct3);
        logic [2:0] n;
        case (funct3)
            F3_B, F3_BU: n = 3'd1;
            F3_H, F3_HU: n = 3'd2;
            default:     n = 3'd4;
        endcase
        return n;
    endfunction

    // Index of the final byte of a transfer (N-1)
    function automatic logic [1:0] lsu_last_idx(input logic [2:0] funct3);
        logic [1:0] k;
        case (funct3)
            F3_B, F3_BU: k = 2'd0;
            F3_H, F3_HU: k = 2'd1;
            default:     k = 2'd3;
        endcase
        return k;
    endfunction

    // Whether a funct3 code is a legal load or store encoding
    function automatic logic lsu_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Width/sign extension of the assembled little-endian load word.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] result
);

    // Pick the low byte/half and extend it according to the load type
    always_comb begin
        result = word;
        case (funct3)
            F3_B:    result = {{24{word[7]}}, word[7:0]};
            F3_H:    result = {{16{word[15]}}, word[15:0]};
            F3_BU:   result = {24'd0, word[7:0]};
            F3_HU:   result = {16'd0, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core request into a sequence of single-byte
// memory accesses (little-endian, address wraps at 32 bits) and returns a
// one-cycle completion pulse with the extended load data or an error flag.
//
// Handshake: a request transfers at a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle and out of reset.
// Request inputs are don't-care while req_ready is 0. The response is a
// single resp_valid pulse with no backpressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_TRAP = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    lsu_state_t  state;

    // Captured request fields
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  last_q;

    // Byte index currently on the memory port
    logic [1:0]  idx_q;
    logic [1:0]  idx_nxt;

    // A read byte is arriving on mem_rdata this cycle, destined for rd_idx_q
    logic        rd_pend_q;
    logic [1:0]  rd_idx_q;
    logic [31:0] rbuf_q;

    logic [31:0] load_word;
    logic [31:0] ext_word;
    logic        reject;

    assign idx_nxt   = idx_q + 2'd1;
    assign req_ready = (state == ST_IDLE) && rst;
    assign reject    = !lsu_legal(req_we, req_funct3) ||
                       (MISALIGN_TRAP && lsu_misaligned(req_funct3, req_addr[1:0]));

    // Merge the byte arriving this cycle into the partially assembled word
    always_comb begin
        load_word = rbuf_q;
        if (rd_pend_q) begin
            load_word[{rd_idx_q, 3'b000} +: 8] = mem_rdata;
        end
    end

    lsu_extend u_extend (
        .funct3 (funct3_q),
        .word   (load_word),
        .result (ext_word)
    );

    // Request capture, byte sequencing, load assembly and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            last_q     <= 2'd0;
            idx_q      <= 2'd0;
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= 2'd0;
            rbuf_q     <= 32'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 8'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            if (rd_pend_q) begin
                rbuf_q <= load_word;
            end
            rd_pend_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_we ? req_wdata : 32'd0;
                        last_q   <= lsu_last_idx(req_funct3);
                        idx_q    <= 2'd0;
                        rbuf_q   <= 32'd0;
                        if (reject) begin
                            // Illegal or trapped: answer immediately, touch no memory
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= ST_XFER;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_we ? req_wdata[7:0] : 8'd0;
                        end
                    end
                end

                ST_XFER: begin
                    // The byte read this cycle returns next cycle
                    rd_pend_q <= !we_q;
                    rd_idx_q  <= idx_q;
                    if (idx_q == last_q) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 8'd0;
                        if (we_q) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'd0;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        idx_q     <= idx_nxt;
                        mem_addr  <= addr_q + {30'd0, idx_nxt};
                        mem_wdata <= wdata_q[{idx_nxt, 3'b000} +: 8];
                    end
                end

                ST_DRAIN: begin
                    // Final byte is on mem_rdata now; load_word already includes it
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ext_word;
                end

                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a request-level model predicts every byte
// access and every response (with its cycle), a per-cycle compare process
// checks the DUT against it, and directed tests pin literal results.
module tb_load_store_unit;

    localparam bit TRAP = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    // Second instance with byte-wise misaligned accesses
    logic        t0_req_valid, t0_req_we;
    logic [2:0]  t0_req_funct3;
    logic [31:0] t0_req_addr, t0_req_wdata;
    logic        t0_req_ready, t0_resp_valid, t0_resp_err;
    logic [31:0] t0_resp_rdata;
    logic        t0_mem_en, t0_mem_we;
    logic [31:0] t0_mem_addr;
    logic [7:0]  t0_mem_wdata;
    logic [7:0]  t0_mem_rdata = 8'd0;

    load_store_unit #(.MISALIGN_TRAP(TRAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MISALIGN_TRAP(1'b0)) dut_t0 (
        .clk(clk), .rst(rst),
        .req_valid(t0_req_valid), .req_ready(t0_req_ready), .req_we(t0_req_we),
        .req_funct3(t0_req_funct3), .req_addr(t0_req_addr), .req_wdata(t0_req_wdata),
        .resp_valid(t0_resp_valid), .resp_rdata(t0_resp_rdata), .resp_err(t0_resp_err),
        .mem_en(t0_mem_en), .mem_we(t0_mem_we), .mem_addr(t0_mem_addr),
        .mem_wdata(t0_mem_wdata), .mem_rdata(t0_mem_rdata)
    );

    // ---------------- checking bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memories ----------------
    // dev_mem is the memory the DUT talks to; ref_mem is the model's view.
    logic [7:0] dev_mem [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic init_mem(input logic [31:0] a, input logic [7:0] d);
        dev_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // ---------------- scoreboard ----------------
    // acc_q entry: {cycle[15:0], we, addr[31:0], wdata[7:0]}
    // exp_q entry: {cycle[15:0], err, rdata[31:0]}
    logic [56:0] acc_q[$];
    logic [48:0] exp_q[$];
    int          free_cyc = 0;
    bit          rst_seen = 1'b0;
    int          acc_log[$];
    logic [31:0] resp_log[$];
    logic        last_err = 1'b0;
    int          last_resp_cyc = 0;

    // Request-level model: what a request must do, from its fields alone
    task automatic model_accept(input int c, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd);
        int          n;
        bit          legal, mis;
        logic [31:0] word, ak;
        logic [1:0]  lo;
        lo = f3[1:0];
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n = (lo == 2'd0) ? 1 : (lo == 2'd1) ? 2 : 4;
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        acc_log.push_back(c);
        if (!legal || (TRAP && mis)) begin
            exp_q.push_back({16'(c + 1), 1'b1, 32'd0});
            free_cyc = c + 2;
            return;
        end
        word = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            if (we) begin
                acc_q.push_back({16'(c + 1 + k), 1'b1, ak, wd[8*k +: 8]});
                ref_mem[ak] = wd[8*k +: 8];
            end else begin
                acc_q.push_back({16'(c + 1 + k), 1'b0, ak, 8'h00});
                word[8*k +: 8] = ref_rd(ak);
            end
        end
        if (we) begin
            exp_q.push_back({16'(c + n + 1), 1'b0, 32'd0});
            free_cyc = c + n + 2;
        end else begin
            case (f3)
                3'd0:    word = 32'($signed(word[7:0]));
                3'd1:    word = 32'($signed(word[15:0]));
                3'd4:    word = {24'd0, word[7:0]};
                3'd5:    word = {16'd0, word[15:0]};
                default: word = word;
            endcase
            exp_q.push_back({16'(c + n + 2), 1'b0, word});
            free_cyc = c + n + 3;
        end
    endtask

    // Per-cycle compare, sampled mid-cycle on the falling edge
    initial begin
        logic [15:0] c16;
        logic [56:0] ea;
        logic [48:0] er;
        forever begin
            @(negedge clk);
            c16 = cyc[15:0];
            if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
            if (rst_seen) begin
                chk("req_ready", req_ready, rst && (cyc >= free_cyc));
                while (acc_q.size() > 0 && acc_q[0][56:41] < c16) begin
                    ea = acc_q.pop_front();
                    checks++; errors++;
                    $display("FAIL mem_missing actual=none required=%h (cycle %0d)", ea, cyc);
                end
                while (exp_q.size() > 0 && exp_q[0][48:33] < c16) begin
                    er = exp_q.pop_front();
                    checks++; errors++;
                    $display("FAIL resp_missing actual=none required=%h (cycle %0d)", er, cyc);
                end
                if (mem_en) begin
                    if (acc_q.size() == 0) begin
                        chk("mem_unexpected", {c16, mem_we, mem_addr, mem_wdata}, 64'd0);
                    end else begin
                        ea = acc_q.pop_front();
                        chk("mem_access", {c16, mem_we, mem_addr, mem_wdata}, ea);
                    end
                end else begin
                    chk("mem_idle", {mem_we, mem_addr, mem_wdata}, 64'd0);
                end
                if (resp_valid) begin
                    resp_log.push_back(resp_rdata);
                    last_err = resp_err;
                    last_resp_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", {c16, resp_err, resp_rdata}, 64'd0);
                    end else begin
                        er = exp_q.pop_front();
                        chk("resp", {c16, resp_err, resp_rdata}, er);
                    end
                end else begin
                    chk("resp_idle", {resp_err, resp_rdata}, 64'd0);
                end
                if (rst && req_valid && cyc >= free_cyc)
                    model_accept(cyc, req_we, req_funct3, req_addr, req_wdata);
            end
            if (!rst) begin
                acc_q.delete();
                exp_q.delete();
                free_cyc = cyc + 1;
                rst_seen = 1'b1;
            end
        end
    end

    // Byte memory read responders: data valid the cycle after the read strobe
    logic        rd_pend = 1'b0, t0_rd_pend = 1'b0;
    logic [31:0] rd_addr = 32'd0, t0_rd_addr = 32'd0;
    initial forever begin
        @(negedge clk);
        rd_pend    = mem_en && !mem_we;
        rd_addr    = mem_addr;
        t0_rd_pend = t0_mem_en && !t0_mem_we;
        t0_rd_addr = t0_mem_addr;
    end
    initial forever begin
        @(posedge clk);
        #1;
        mem_rdata    = rd_pend ? dev_rd(rd_addr) : 8'($urandom);
        t0_mem_rdata = t0_rd_pend ? dev_rd(t0_rd_addr) : 8'($urandom);
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep);
        bit acc;
        int n;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_ready && rst;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accepted", acc, 1);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((acc_q.size() != 0 || exp_q.size() != 0 || cyc < free_cyc) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", acc_q.size() + exp_q.size(), 0);
    endtask

    task automatic single(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input logic err,
                          input logic [31:0] rdata);
        issue(we, f3, a, wd, 1'b0);
        wait_done();
        chk("latency", last_resp_cyc - acc_log[acc_log.size() - 1], lat);
        chk("err", last_err, err);
        chk("rdata", resp_log[resp_log.size() - 1], rdata);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rc;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        t0_req_valid = 1'b0; t0_req_we = 1'b0; t0_req_funct3 = 3'd0;
        t0_req_addr = 32'd0; t0_req_wdata = 32'd0;
        init_mem(32'h203, 8'h80);
        init_mem(32'h0, 8'h11); init_mem(32'h1, 8'h22);
        init_mem(32'h2, 8'h33); init_mem(32'h3, 8'h44);
        init_mem(32'hFFFFFFFC, 8'hA1); init_mem(32'hFFFFFFFD, 8'hB2);
        init_mem(32'hFFFFFFFE, 8'hC3); init_mem(32'hFFFFFFFF, 8'hD4);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {req_ready, mem_en, resp_valid, resp_rdata}, {3'b100, 32'd0});
        @(posedge clk); #1;

        // sw 0xDEADBEEF @0x100
        single(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5, 1'b0, 32'd0);
        chk("sw_bytes", {dev_rd(32'h103), dev_rd(32'h102), dev_rd(32'h101), dev_rd(32'h100)},
            32'hDEADBEEF);

        // byte loads with sign / zero extension
        single(1'b0, 3'b000, 32'h203, 32'd0, 3, 1'b0, 32'hFFFFFF80);
        single(1'b0, 3'b100, 32'h203, 32'd0, 3, 1'b0, 32'h00000080);

        // misaligned half with trapping enabled, illegal codes
        single(1'b0, 3'b001, 32'h101, 32'd0, 1, 1'b1, 32'd0);
        single(1'b0, 3'b011, 32'h100, 32'd0, 1, 1'b1, 32'd0);
        single(1'b1, 3'b100, 32'h100, 32'h12345678, 1, 1'b1, 32'd0);

        // word/half loads and narrower stores
        single(1'b0, 3'b010, 32'h0, 32'd0, 6, 1'b0, 32'h44332211);
        single(1'b0, 3'b001, 32'h2, 32'd0, 4, 1'b0, 32'h00004433);
        single(1'b0, 3'b101, 32'h102, 32'd0, 4, 1'b0, 32'h0000DEAD);
        single(1'b0, 3'b001, 32'h102, 32'd0, 4, 1'b0, 32'hFFFFDEAD);
        single(1'b1, 3'b001, 32'h200, 32'h12345678, 3, 1'b0, 32'd0);
        chk("sh_bytes", {dev_rd(32'h201), dev_rd(32'h200)}, 16'h5678);
        single(1'b1, 3'b000, 32'h1FF, 32'h000000AB, 2, 1'b0, 32'd0);
        single(1'b0, 3'b010, 32'h1FC, 32'd0, 6, 1'b0, 32'hAB000000);

        // misaligned half performed byte-wise on the non-trapping instance
        t0_req_valid = 1'b1; t0_req_we = 1'b0; t0_req_funct3 = 3'b001; t0_req_addr = 32'h101;
        @(negedge clk);
        chk("t0_ready", t0_req_ready, 1);
        @(posedge clk); #1;
        t0_req_valid = 1'b0;
        @(negedge clk);
        chk("t0_c1", {t0_mem_en, t0_mem_we, t0_mem_addr, t0_resp_valid}, {2'b10, 32'h101, 1'b0});
        @(negedge clk);
        chk("t0_c2", {t0_mem_en, t0_mem_we, t0_mem_addr, t0_resp_valid}, {2'b10, 32'h102, 1'b0});
        @(negedge clk);
        chk("t0_c3", {t0_mem_en, t0_resp_valid}, 2'b00);
        @(negedge clk);
        chk("t0_c4", {t0_resp_valid, t0_resp_err, t0_resp_rdata}, {2'b10, 32'hFFFFADBE});
        @(posedge clk); #1;
        @(posedge clk); #1;

        // lw @0x0 aborted by reset during cycle C+2
        rc = resp_log.size();
        issue(1'b0, 3'b010, 32'h0, 32'd0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", {req_ready, mem_en}, 2'b10);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_resp", resp_log.size(), rc);

        // back-to-back words across the top of the address space
        issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'd0, 1'b1);
        issue(1'b0, 3'b010, 32'h0, 32'd0, 1'b0);
        wait_done();
        chk("b2b_gap", acc_log[acc_log.size() - 1] - acc_log[acc_log.size() - 2], 7);
        chk("b2b_first", resp_log[resp_log.size() - 2], 32'hD4C3B2A1);
        chk("b2b_second", resp_log[resp_log.size() - 1], 32'h44332211);
        chk("b2b_err", last_err, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
